// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - IF-stage program counter with redirect, halt, stall and fetch handshake
// Optional build macro: PC_GEN_MISALIGN_TRAP_EN (misaligned redirects load TRAP_VEC)
module pc_gen_unit #(
  parameter int          WIDTH     = 32,
  parameter int          STEP      = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0004
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  input  logic             pc_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             pc_valid,
  output logic             redir_ack,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
  localparam logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] TRAP_PC    = WIDTH'(TRAP_VEC);
`ifdef PC_GEN_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_pc_valid;
  logic             r_redir_ack;
  logic             r_misalign;

  logic             w_misaligned;
  logic [WIDTH-1:0] w_redir_pc;
  logic [WIDTH-1:0] w_pc_plus;
  logic             w_advance;

  // Redirect target decode: alignment check against the step size and optional trap substitution
  always_comb begin
    w_misaligned = |(redir_target & ALIGN_MASK);
    w_redir_pc   = (w_misaligned && TRAP_EN) ? TRAP_PC : redir_target;
    w_pc_plus    = r_pc + STEP_W;
    w_advance    = r_pc_valid & pc_ready & ~stall;
  end

  // PC state machine; BOOT lasts one cycle, so a redirect seen in BOOT is taken straight into the PC on RUN entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_pc_valid  <= 1'b0;
      r_redir_ack <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_redir_ack <= 1'b0;
      if (redir_valid) begin
        r_pc        <= w_redir_pc;
        r_redir_ack <= 1'b1;
        r_state     <= ST_RUN;
        r_pc_valid  <= 1'b1;
        if (w_misaligned) begin
          r_misalign <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_BOOT: begin
            r_state    <= ST_RUN;
            r_pc_valid <= 1'b1;
          end
          ST_RUN: begin
            if (halt) begin
              r_state    <= ST_HALT;
              r_pc_valid <= 1'b0;
            end else if (w_advance) begin
              r_pc <= w_pc_plus;
            end
          end
          ST_HALT: begin
            r_pc_valid <= 1'b0;
          end
          default: begin
            r_state    <= ST_BOOT;
            r_pc_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pc        = r_pc;
  assign pc_plus   = w_pc_plus;
  assign pc_valid  = r_pc_valid;
  assign redir_ack = r_redir_ack;
  assign misalign  = r_misalign;

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - directed self-checking bench for pc_gen_unit (32-bit and 16-bit instances)
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        halt;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        pc_ready;

  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        pc_valid;
  logic        redir_ack;
  logic        misalign;

  logic [15:0] redir_target_16;
  logic [15:0] pc_16;
  logic [15:0] pc_plus_16;
  logic        pc_valid_16;
  logic        redir_ack_16;
  logic        misalign_16;

  int n_checks = 0;
  int n_errors = 0;

  assign redir_target_16 = redir_target[15:0];

  always #5 clk = ~clk;

  pc_gen_unit #(.WIDTH(32), .STEP(4), .RESET_VEC(32'h0), .TRAP_VEC(32'h4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .halt         (halt),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .pc_ready     (pc_ready),
    .pc           (pc),
    .pc_plus      (pc_plus),
    .pc_valid     (pc_valid),
    .redir_ack    (redir_ack),
    .misalign     (misalign)
  );

  pc_gen_unit #(.WIDTH(16), .STEP(4), .RESET_VEC(32'h0), .TRAP_VEC(32'h4)) dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .halt         (halt),
    .redir_valid  (redir_valid),
    .redir_target (redir_target_16),
    .pc_ready     (pc_ready),
    .pc           (pc_16),
    .pc_plus      (pc_plus_16),
    .pc_valid     (pc_valid_16),
    .redir_ack    (redir_ack_16),
    .misalign     (misalign_16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redir_valid  = 1'b1;
    redir_target = target;
    step();
    redir_valid  = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_seq [4];
    logic [31:0] exp_misal_pc;
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
`ifdef PC_GEN_MISALIGN_TRAP_EN
    exp_misal_pc = 32'h4;
`else
    exp_misal_pc = 32'h102;
`endif

    rst_n = 1'b0; stall = 1'b0; halt = 1'b0;
    redir_valid = 1'b0; redir_target = '0; pc_ready = 1'b1;
    step(); step();
    check("rst_pc", pc, 0);
    check("rst_valid", pc_valid, 0);
    check("rst_ack", redir_ack, 0);
    check("rst_misalign", misalign, 0);

    // release: BOOT cycle then sequential fetch
    rst_n = 1'b1;
    check("boot_valid", pc_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("seq_pc%0d", i), pc, exp_seq[i]);
      check($sformatf("seq_valid%0d", i), pc_valid, 1);
      check($sformatf("seq_plus%0d", i), pc_plus, exp_seq[i] + 32'h4);
    end
    step();
    check("seq_pc10", pc, 32'h10);

    // IF port back-pressure
    pc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_pc%0d", i), pc, 32'h10);
      check($sformatf("hold_valid%0d", i), pc_valid, 1);
    end
    pc_ready = 1'b1;
    step();
    check("accept_pc", pc, 32'h14);

    // stall in RUN holds pc with the request still valid
    stall = 1'b1;
    step(); step();
    check("stall_pc", pc, 32'h14);
    check("stall_valid", pc_valid, 1);
    stall = 1'b0;
    step();
    check("unstall_pc", pc, 32'h18);

    // redirect beats stall
    pc_ready = 1'b0;
    redirect(32'h20);
    check("redir20_pc", pc, 32'h20);
    stall = 1'b1;
    redirect(32'h100);
    check("redir_stall_pc", pc, 32'h100);
    check("redir_stall_ack", redir_ack, 1);
    stall = 1'b0;
    step();
    check("ack_pulse_end", redir_ack, 0);
    check("redir_hold_pc", pc, 32'h100);

    // halt: frozen despite stall toggling and ready
    redirect(32'h40);
    pc_ready = 1'b1;
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_pc", pc, 32'h40);
    check("halt_valid", pc_valid, 0);
    for (int i = 0; i < 5; i++) begin
      stall = i[0];
      halt  = i[1];
      step();
      check($sformatf("halted_pc%0d", i), pc, 32'h40);
      check($sformatf("halted_valid%0d", i), pc_valid, 0);
    end
    stall = 1'b0; halt = 1'b0; pc_ready = 1'b0;
    redirect(32'h200);
    check("unhalt_pc", pc, 32'h200);
    check("unhalt_valid", pc_valid, 1);
    check("unhalt_ack", redir_ack, 1);

    // wrap-around at 16 and 32 bits
    redirect(32'h0000_FFFC);
    check("w16_pc", pc_16, 16'hFFFC);
    check("w16_plus", pc_plus_16, 16'h0000);
    check("w32_plus_nowrap", pc_plus, 32'h1_0000);
    pc_ready = 1'b1;
    step();
    pc_ready = 1'b0;
    check("w16_wrap_pc", pc_16, 16'h0000);
    check("w16_wrap_plus", pc_plus_16, 16'h0004);
    check("w32_pc_10000", pc, 32'h1_0000);
    redirect(32'hFFFF_FFFC);
    check("w32_plus_wrap", pc_plus, 32'h0);
    pc_ready = 1'b1;
    step();
    pc_ready = 1'b0;
    check("w32_wrap_pc", pc, 32'h0);
    check("w32_no_misalign", misalign, 0);
    check("w16_no_misalign", misalign_16, 0);

    // misaligned redirect, sticky flag
    redirect(32'h102);
    check("mis_flag", misalign, 1);
    check("mis_pc", pc, exp_misal_pc);
    check("mis_ack", redir_ack, 1);
    redirect(32'h300);
    check("mis_sticky", misalign, 1);
    check("mis_next_pc", pc, 32'h300);
    step();
    check("mis_sticky2", misalign, 1);

    // async reset mid-operation, then redirect seen during BOOT
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 0);
    check("arst_misalign", misalign, 0);
    check("arst_valid", pc_valid, 0);
    step();
    redir_valid  = 1'b1;
    redir_target = 32'h500;
    rst_n = 1'b1;
    check("boot2_valid", pc_valid, 0);
    step();
    redir_valid = 1'b0;
    check("boot_redir_pc", pc, 32'h500);
    check("boot_redir_valid", pc_valid, 1);
    check("boot_redir_ack", redir_ack, 1);
    step();
    check("boot_redir_ack_end", redir_ack, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
